// File: rtl/pkg_fb_defs.sv
// Shared framebuffer definitions: geometry, pixel format, frame sync byte,
// and the frame loader state encoding.
package pkg_fb_defs;

    localparam int FB_WIDTH       = 320;
    localparam int FB_HEIGHT      = 240;
    localparam int NUM_PIXELS     = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W         = 17;
    localparam int PIX_W          = 12;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int TIMEOUT_CYCLES = 1000000;
    localparam int TO_W           = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } fb_state_t;

endpackage

// File: rtl/uart_frame_loader.sv
// Packs UART byte pairs into RGB444 pixels after a sync byte and writes them
// to sequential framebuffer addresses, aborting a frame on inter-byte timeout.
module uart_frame_loader #(
    parameter int         ADDR_W         = pkg_fb_defs::ADDR_W,
    parameter int         NUM_PIXELS     = pkg_fb_defs::NUM_PIXELS,
    parameter logic [7:0] SYNC_BYTE      = pkg_fb_defs::SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = pkg_fb_defs::TIMEOUT_CYCLES,
    parameter int         TO_W           = pkg_fb_defs::TO_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err,
    output logic [1:0]        state_dbg
);
    import pkg_fb_defs::*;

    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    // Handshake: rx_valid is a single-cycle strobe with no back-pressure; every
    // strobe is consumed in the cycle it is seen. wr_en is a single-cycle write
    // strobe with wr_addr/wr_data valid in that same cycle.

    fb_state_t         state, state_n;
    logic [7:0]        hi_byte, hi_byte_n;
    logic [ADDR_W-1:0] pix_cnt, pix_cnt_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic              wr_en_n, frame_done_n, timeout_err_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [11:0]       wr_data_n;
    logic              expired;

    assign expired = (to_cnt == TO_LAST);

    always_comb begin
        state_n       = state;
        hi_byte_n     = hi_byte;
        pix_cnt_n     = pix_cnt;
        to_cnt_n      = to_cnt;
        wr_en_n       = 1'b0;
        wr_addr_n     = wr_addr;
        wr_data_n     = wr_data;
        frame_done_n  = 1'b0;
        timeout_err_n = timeout_err;
        case (state)
            IDLE: begin
                to_cnt_n = '0;
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_n       = WAIT_HI;
                    timeout_err_n = 1'b0;
                end
            end
            WAIT_HI: begin
                if (rx_valid) begin
                    hi_byte_n = rx_data;
                    to_cnt_n  = '0;
                    state_n   = WAIT_LO;
                end else if (expired) begin
                    state_n       = IDLE;
                    pix_cnt_n     = '0;
                    to_cnt_n      = '0;
                    timeout_err_n = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            WAIT_LO: begin
                if (rx_valid) begin
                    to_cnt_n  = '0;
                    wr_en_n   = 1'b1;
                    wr_addr_n = pix_cnt;
                    // Upper nibble of the low byte carries no colour information.
                    wr_data_n = {hi_byte, rx_data[3:0]};
                    if (pix_cnt == PIX_LAST) begin
                        frame_done_n = 1'b1;
                        pix_cnt_n    = '0;
                        state_n      = IDLE;
                    end else begin
                        pix_cnt_n = pix_cnt + 1'b1;
                        state_n   = WAIT_HI;
                    end
                end else if (expired) begin
                    state_n       = IDLE;
                    pix_cnt_n     = '0;
                    to_cnt_n      = '0;
                    timeout_err_n = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                pix_cnt_n = '0;
                to_cnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hi_byte     <= '0;
            pix_cnt     <= '0;
            to_cnt      <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            hi_byte     <= hi_byte_n;
            pix_cnt     <= pix_cnt_n;
            to_cnt      <= to_cnt_n;
            wr_en       <= wr_en_n;
            wr_addr     <= wr_addr_n;
            wr_data     <= wr_data_n;
            frame_done  <= frame_done_n;
            timeout_err <= timeout_err_n;
        end
    end

    // The FSM is already IDLE during the final write; frame_done holds busy
    // up for that cycle so it drops one cycle after the last pixel.
    assign busy      = (state != IDLE) || frame_done;
    assign state_dbg = state;

endmodule
